uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer directly upstream of the UART transmitter. It accepts bytes from the CPU/CSR write path into a circular FIFO and hands them one at a time to the transmitter. A byte is launched only when the transmitter reports it is ready, and the next byte waits until the transmitter reports the current one sent. It also provides full, empty, level and sticky-overflow status for the CSR block.

---
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 tb/tb_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers CSR writes and launches one byte
// per transmitter frame, with full/empty/level and sticky overflow status.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     tx_data_ready,
  input  logic                     data_sent,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake: a byte is launched (tx_start for one cycle) only from IDLE while
  // tx_data_ready is high; the next launch waits for the data_sent pulse.
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_SENT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              ovf_set;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign fsm_state = state;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push    = wr_en && !full && !flush;
  assign ovf_set = wr_en && full && !flush;
  assign pop     = (state == IDLE) && !empty && tx_data_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // flush leaves the launch sequencer alone so an in-flight byte completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= WAIT_SENT;
          end
        end
        WAIT_SENT: begin
          if (data_sent) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all compared
// each cycle against a queue-based reference of the FIFO and launch rules.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int LW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              flush = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              tx_data_ready = 1'b0;
  logic              data_sent = 1'b0;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              fsm_state;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .ovf_clr(ovf_clr), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_data_ready(tx_data_ready),
    .data_sent(data_sent), .tx_start(tx_start), .tx_data(tx_data),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model: queue of stored bytes, a busy flag for a launched byte
  // awaiting data_sent, the sticky overflow bit and the last launched byte.
  logic [DATA_W-1:0] exp_q[$];
  bit                busy;
  bit                exp_ovf;
  bit                exp_start;
  logic [DATA_W-1:0] exp_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    busy      = 1'b0;
    exp_ovf   = 1'b0;
    exp_start = 1'b0;
    exp_data  = '0;
  endtask

  task automatic check_outputs();
    check("level",     32'(level),     32'(exp_q.size()));
    check("empty",     32'(empty),     32'(exp_q.size() == 0));
    check("full",      32'(full),      32'(exp_q.size() == DEPTH));
    check("overflow",  32'(overflow),  32'(exp_ovf));
    check("tx_start",  32'(tx_start),  32'(exp_start));
    check("tx_data",   32'(tx_data),   32'(exp_data));
    check("fsm_state", 32'(fsm_state), 32'(busy));
  endtask

  // One clock: model decisions use pre-edge state and inputs, outputs are
  // checked on the following falling edge.
  task automatic tick();
    bit is_full, launch, push_ok, ovf_set;
    is_full = (exp_q.size() == DEPTH);
    launch  = !busy && exp_q.size() != 0 && tx_data_ready && !flush;
    push_ok = wr_en && !is_full && !flush;
    ovf_set = wr_en && is_full && !flush;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (launch)  exp_data = exp_q.pop_front();
      if (push_ok) exp_q.push_back(wr_data);
    end
    exp_start = launch;
    if (launch) busy = 1'b1;
    else if (busy && data_sent) busy = 1'b0;
    if (ovf_set)      exp_ovf = 1'b1;
    else if (ovf_clr) exp_ovf = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Waits a bounded number of cycles for a launch, then acknowledges it.
  task automatic take_byte(input string tag, input logic [DATA_W-1:0] want);
    int guard = 0;
    tx_data_ready = 1'b1;
    while (!tx_start && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_launch_seen"}, 32'(guard < 20), 32'd1);
    check({tag, "_byte"}, 32'(tx_data), 32'(want));
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;
  endtask

  initial begin
    int starts;
    int frame;
    logic [DATA_W-1:0] want;

    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    tick();

    // Single byte
    tx_data_ready = 1'b1;
    push_byte(8'hA5);
    tick();
    check("single_start", 32'(tx_start), 32'd1);
    check("single_data", 32'(tx_data), 32'hA5);
    starts = 0;
    repeat (5) begin tick(); starts += int'(tx_start); end
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;
    repeat (3) begin tick(); starts += int'(tx_start); end
    check("single_no_relaunch", 32'(starts), 32'd0);

    // Burst fill, overflow (set beats clear), ordered drain
    tx_data_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    check("burst_full", 32'(full), 32'd1);
    check("burst_level", 32'(level), 32'd16);
    ovf_clr = 1'b1;
    push_byte(8'h55);
    ovf_clr = 1'b0;
    check("burst_ovf_set", 32'(overflow), 32'd1);
    check("burst_level_after_drop", 32'(level), 32'd16);
    for (int i = 1; i <= 16; i++) take_byte("burst", 8'(i));
    check("burst_empty", 32'(empty), 32'd1);
    check("burst_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("burst_ovf_cleared", 32'(overflow), 32'd0);

    // Steady level 3 with simultaneous push and pop across the pointer wrap
    tx_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
    for (int k = 0; k < 40; k++) begin
      tx_data_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'h80 + 8'(k);
      tick();
      tx_data_ready = 1'b0;
      wr_en = 1'b0;
      want = (k < 3) ? 8'hC0 + 8'(k) : 8'h80 + 8'(k - 3);
      check("wrap_level", 32'(level), 32'd3);
      check("wrap_order", 32'(tx_data), 32'(want));
      data_sent = 1'b1;
      tick();
      data_sent = 1'b0;
    end
    for (int k = 37; k < 40; k++) take_byte("wrap_drain", 8'h80 + 8'(k));

    // Flush with a byte in flight and a same-cycle push
    tx_data_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'h30 + 8'(i));
    tx_data_ready = 1'b1;
    tick();
    tx_data_ready = 1'b0;
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_inflight_data", 32'(tx_data), 32'h30);
    check("flush_still_waiting", 32'(fsm_state), 32'd1);
    tx_data_ready = 1'b1;
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;
    starts = 0;
    repeat (6) begin tick(); starts += int'(tx_start); end
    check("flush_no_launch", 32'(starts), 32'd0);

    // Asynchronous reset while waiting for data_sent with 4 bytes queued
    tx_data_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    tx_data_ready = 1'b1;
    tick();
    tx_data_ready = 1'b0;
    check("areset_pre_level", 32'(level), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tx_data_ready = 1'b1;
    starts = 0;
    repeat (4) begin tick(); starts += int'(tx_start); end
    check("areset_no_launch", 32'(starts), 32'd0);
    push_byte(8'h9E);
    tick();
    check("areset_new_launch", 32'(tx_start), 32'd1);
    check("areset_new_data", 32'(tx_data), 32'h9E);
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;

    // Random traffic with an emulated transmitter of random frame length
    frame = 0;
    for (int c = 0; c < 600; c++) begin
      wr_en         = ($urandom_range(0, 2) != 0);
      wr_data       = 8'($urandom_range(0, 255));
      tx_data_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 59) == 0);
      ovf_clr       = ($urandom_range(0, 14) == 0);
      data_sent     = 1'b0;
      if (frame > 0) begin
        frame--;
        if (frame == 0) data_sent = 1'b1;
      end else if (!busy && $urandom_range(0, 19) == 0) begin
        data_sent = 1'b1;
      end
      tick();
      if (exp_start) frame = $urandom_range(1, 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
